// File: rtl/wb_arbiter_rr_pkg.sv
// rtl/wb_arbiter_rr_pkg.sv - shared types and constants for the round-robin Wishbone arbiter
package wb_arbiter_rr_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_GRANT = 2'd1,
        STATE_ABORT = 2'd2
    } state_t;

    localparam int CNT_W = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_rr_pick.sv
// rtl/wb_arbiter_rr_rr_pick.sv - combinational round-robin search starting after last_idx
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_idx_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset to the nearest so the closest requester overwrites.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IDX_W'((int'(last_idx_i) + k) % N);
            if (req_i[cand]) begin
                idx_o   = cand;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// rtl/wb_arbiter_rr.sv - round-robin Wishbone arbiter with per-phase ack timeout
module wb_arbiter_rr
    import wb_arbiter_rr_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_MASTERS-1:0] m_cyc_i,
    input  logic [NUM_MASTERS-1:0] m_stb_i,
    output logic [NUM_MASTERS-1:0] m_ack_o,
    output logic [NUM_MASTERS-1:0] m_err_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    input  logic                   s_ack_i,
    output logic [NUM_MASTERS-1:0] gnt_o
);

    localparam int IDX_W = idx_width(NUM_MASTERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]       last_idx_q, last_idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_first_q, err_first_d;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic                   cyc_g, stb_g;
    logic [NUM_MASTERS-1:0] gnt_onehot;

    rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i      (m_cyc_i),
        .last_idx_i (last_idx_q),
        .idx_o      (pick_idx),
        .valid_o    (pick_valid)
    );

    assign cyc_g      = m_cyc_i[gnt_idx_q];
    assign stb_g      = m_stb_i[gnt_idx_q];
    assign gnt_onehot = NUM_MASTERS'(1) << gnt_idx_q;

    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        last_idx_d  = last_idx_q;
        cnt_d       = cnt_q;
        err_first_d = 1'b0;
        gnt_o       = '0;
        s_cyc_o     = 1'b0;
        s_stb_o     = 1'b0;
        m_ack_o     = '0;
        m_err_o     = '0;
        case (state_q)
            STATE_IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    state_d   = STATE_GRANT;
                    gnt_idx_d = pick_idx;
                end
            end
            STATE_GRANT: begin
                gnt_o   = gnt_onehot;
                s_cyc_o = cyc_g;
                s_stb_o = stb_g;
                // An ack outside a strobed phase belongs to nobody.
                if (stb_g && s_ack_i) begin
                    m_ack_o = gnt_onehot;
                end
                cnt_d = (stb_g && !s_ack_i) ? cnt_q + 8'd1 : '0;
                if (!cyc_g) begin
                    state_d    = STATE_IDLE;
                    last_idx_d = gnt_idx_q;
                    cnt_d      = '0;
                end else if (stb_g && !s_ack_i && cnt_q == CNT_LAST) begin
                    state_d     = STATE_ABORT;
                    err_first_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            STATE_ABORT: begin
                gnt_o = gnt_onehot;
                if (err_first_q) begin
                    m_err_o = gnt_onehot;
                end
                if (!cyc_g) begin
                    state_d    = STATE_IDLE;
                    last_idx_d = gnt_idx_q;
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= STATE_IDLE;
            gnt_idx_q   <= '0;
            last_idx_q  <= IDX_LAST;
            cnt_q       <= '0;
            err_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            last_idx_q  <= last_idx_d;
            cnt_q       <= cnt_d;
            err_first_q <= err_first_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// tb/tb_wb_arbiter_rr.sv - directed self-checking bench for wb_arbiter_rr
module tb_wb_arbiter_rr;

    localparam int N = 4;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [N-1:0] m_cyc_i;
    logic [N-1:0] m_stb_i;
    logic [N-1:0] m_ack_o;
    logic [N-1:0] m_err_o;
    logic         s_cyc_o;
    logic         s_stb_o;
    logic         s_ack_i;
    logic [N-1:0] gnt_o;

    int errors = 0;
    int checks = 0;

    wb_arbiter_rr #(
        .NUM_MASTERS (N),
        .TIMEOUT     (16)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_ack_i (s_ack_i),
        .gnt_o   (gnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    logic [1:0]   e;
    logic [N-1:0] oh;

    initial begin
        rst_i   = 1'b1;
        m_cyc_i = '0;
        m_stb_i = '0;
        s_ack_i = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 8'(gnt_o), 8'h0);
        chk("rst_s_cyc", 8'(s_cyc_o), 8'h0);
        chk("rst_s_stb", 8'(s_stb_o), 8'h0);
        chk("rst_m_ack", 8'(m_ack_o), 8'h0);
        chk("rst_m_err", 8'(m_err_o), 8'h0);

        // All four request; each drops after one acked phase.
        rst_i   = 1'b0;
        m_cyc_i = 4'b1111;
        m_stb_i = 4'b1111;
        #1;
        chk("gnt_before_edge", 8'(gnt_o), 8'h0);
        tick();
        chk("first_s_cyc", 8'(s_cyc_o), 8'h1);
        for (int i = 0; i < 5; i++) begin
            e  = 2'(i % N);
            oh = 4'b0001 << e;
            chk("rr_gnt", 8'(gnt_o), 8'(oh));
            s_ack_i = 1'b1;
            #1;
            chk("rr_ack", 8'(m_ack_o), 8'(oh));
            tick();
            s_ack_i    = 1'b0;
            m_cyc_i[e] = 1'b0;
            m_stb_i[e] = 1'b0;
            tick();
            chk("rr_idle_gap", 8'(gnt_o), 8'h0);
            m_cyc_i[e] = 1'b1;
            m_stb_i[e] = 1'b1;
            tick();
        end
        m_cyc_i = '0;
        m_stb_i = '0;
        tick();

        // Lone master 1 re-requests; ack without strobe is dropped.
        m_cyc_i = 4'b0010;
        tick();
        chk("single_gnt", 8'(gnt_o), 8'h02);
        chk("single_stb_low", 8'(s_stb_o), 8'h0);
        s_ack_i = 1'b1;
        #1;
        chk("ack_no_stb", 8'(m_ack_o), 8'h0);
        s_ack_i = 1'b0;
        m_cyc_i = '0;
        tick();
        chk("single_idle", 8'(gnt_o), 8'h0);
        m_cyc_i = 4'b0010;
        tick();
        chk("single_regnt", 8'(gnt_o), 8'h02);
        m_cyc_i = '0;
        tick();

        // Master 2 owns the bus while master 0 raises cyc.
        m_cyc_i = 4'b0100;
        tick();
        chk("np_gnt2", 8'(gnt_o), 8'h04);
        m_cyc_i = 4'b0101;
        tick();
        chk("np_hold_a", 8'(gnt_o), 8'h04);
        tick();
        chk("np_hold_b", 8'(gnt_o), 8'h04);
        m_cyc_i = 4'b0001;
        tick();
        chk("np_idle", 8'(gnt_o), 8'h0);
        tick();
        chk("np_gnt0", 8'(gnt_o), 8'h01);
        m_cyc_i = '0;
        tick();

        // Master 1 strobes with no ack: abort after 16 waiting cycles.
        m_cyc_i = 4'b0010;
        m_stb_i = 4'b0010;
        tick();
        repeat (15) tick();
        chk("to_16th_cyc", 8'(s_cyc_o), 8'h1);
        chk("to_16th_err", 8'(m_err_o), 8'h0);
        tick();
        chk("to_err", 8'(m_err_o), 8'h02);
        chk("to_s_cyc", 8'(s_cyc_o), 8'h0);
        chk("to_s_stb", 8'(s_stb_o), 8'h0);
        chk("to_m_ack", 8'(m_ack_o), 8'h0);
        tick();
        chk("to_err_once", 8'(m_err_o), 8'h0);
        chk("to_s_cyc_hold", 8'(s_cyc_o), 8'h0);
        m_cyc_i = '0;
        m_stb_i = '0;
        tick();
        chk("to_release", 8'(gnt_o), 8'h0);

        // Master 2: ack on the 16th waiting cycle beats the timeout.
        m_cyc_i = 4'b0100;
        m_stb_i = 4'b0100;
        tick();
        repeat (15) tick();
        s_ack_i = 1'b1;
        #1;
        chk("edge_ack", 8'(m_ack_o), 8'h04);
        tick();
        s_ack_i = 1'b0;
        #1;
        chk("edge_no_err", 8'(m_err_o), 8'h0);
        chk("edge_still_gnt", 8'(gnt_o), 8'h04);
        repeat (15) tick();
        chk("restart_cyc", 8'(s_cyc_o), 8'h1);
        chk("restart_err", 8'(m_err_o), 8'h0);
        tick();
        chk("restart_abort", 8'(m_err_o), 8'h04);
        m_cyc_i = '0;
        m_stb_i = '0;
        tick();

        // Reset while master 3 owns the bus.
        m_cyc_i = 4'b1000;
        m_stb_i = 4'b1000;
        tick();
        chk("pre_rst_gnt", 8'(gnt_o), 8'h08);
        rst_i = 1'b1;
        tick();
        chk("mid_rst_s_cyc", 8'(s_cyc_o), 8'h0);
        chk("mid_rst_gnt", 8'(gnt_o), 8'h0);
        chk("mid_rst_err", 8'(m_err_o), 8'h0);
        rst_i = 1'b0;
        tick();
        chk("post_rst_gnt", 8'(gnt_o), 8'h08);
        chk("post_rst_s_cyc", 8'(s_cyc_o), 8'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_rr.md
WB_ARBITER_RR -- requirements
Module: wb_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting Wishbone masters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 16, max cycles a strobed phase may wait for ack before abort (1..255).
REQ-003 SHALL have port clk_i  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port m_cyc_i  input  NUM_MASTERS  per-master cyc; a high bit is a bus request.
REQ-006 SHALL have port m_stb_i  input  NUM_MASTERS  per-master stb.
REQ-007 SHALL have port m_ack_o  output  NUM_MASTERS  per-master ack, routed from slave.
REQ-008 SHALL have port m_err_o  output  NUM_MASTERS  per-master err, timeout abort indication.
REQ-009 SHALL have port s_cyc_o  output  1  cyc to shared slave.
REQ-010 SHALL have port s_stb_o  output  1  stb to shared slave.
REQ-011 SHALL have port s_ack_i  input  1  ack from shared slave.
REQ-012 SHALL have port gnt_o  output  NUM_MASTERS  one-hot current grant; all-zero when no grant.

Function
REQ-013 SHALL implement states STATE_IDLE, STATE_GRANT, STATE_ABORT.
REQ-014 IDLE: when any m_cyc_i bit is high, SHALL register grant to the first requester searching from (last_idx+1) mod NUM_MASTERS upward with wrap, go to GRANT; else stay IDLE.
REQ-015 Grant decision SHALL take exactly one clock: request seen at edge N, gnt_o and s_cyc_o high after edge N+1.
REQ-016 GRANT: s_cyc_o = m_cyc_i[g], s_stb_o = m_stb_i[g], m_ack_o[g] = s_ack_i, combinational from registered grant index g; all other m_ack_o bits SHALL be 0.
REQ-017 GRANT: grant SHALL be held for the full cycle regardless of other requests (no preemption); when m_cyc_i[g] is low at a clock edge SHALL set last_idx=g, clear gnt_o, go to IDLE (one idle cycle between owners minimum).
REQ-018 s_ack_i arriving while s_stb_o is low SHALL be ignored (not routed).
REQ-019 Timeout counter SHALL reset to 0 on entering GRANT and on every cycle with s_ack_i high or s_stb_o low; SHALL increment by 1 on each GRANT cycle with s_stb_o high and s_ack_i low.
REQ-020 When counter equals TIMEOUT-1 and s_ack_i is low, SHALL go to ABORT at that edge.
REQ-021 ABORT: s_cyc_o=0, s_stb_o=0, m_ack_o=0; m_err_o[g] SHALL be high in the first ABORT cycle only; SHALL stay in ABORT until m_cyc_i[g] is low, then set last_idx=g and go to IDLE.
REQ-022 s_ack_i and timeout on same edge: ack SHALL win, no abort.
REQ-023 Counter width SHALL be 8 bits; no wrap possible given REQ-002 range.
REQ-024 Only one bit of gnt_o, m_ack_o, m_err_o SHALL ever be high.

Reset
REQ-025 On rst_i high at an edge: state=IDLE, gnt_o=0, last_idx=NUM_MASTERS-1 (so master 0 wins first), counter=0; s_cyc_o, s_stb_o, m_ack_o, m_err_o all 0 the following cycle.
REQ-026 Reset mid-GRANT or mid-ABORT SHALL drop s_cyc_o without err pulse; rst_i SHALL take priority over all transitions.

Structure
REQ-027 state_t enum (STATE_IDLE, STATE_GRANT, STATE_ABORT) SHALL live in package wb_arbiter_rr_pkg.
REQ-028 Round-robin next-requester search SHALL be a combinational sub-module rr_pick (inputs request vector, last_idx; outputs index, valid).

Verification
REQ-029 After reset, m_cyc_i=4'b1111 held -> gnt_o=4'b0001 one cycle later; each master dropping cyc after one acked phase -> grant order 0,1,2,3,0.
REQ-030 Master 2 granted, master 0 raises cyc mid-cycle -> gnt_o stays 4'b0100 until m_cyc_i[2] low, then one IDLE cycle, then 4'b0001.
REQ-031 Master 1 granted, stb high, s_ack_i never asserted, TIMEOUT=16 -> after 16 strobed cycles m_err_o=4'b0010 for one cycle, s_cyc_o=0 until m_cyc_i[1] drops.
REQ-032 Ack on exactly the 16th waiting cycle -> m_ack_o[g]=1, no m_err_o, remain GRANT.
REQ-033 rst_i asserted while master 3 granted -> next cycle s_cyc_o=0, gnt_o=0, m_err_o=0; with m_cyc_i=4'b1000 still high, grant 4'b1000 re-issued one cycle after rst_i low.
REQ-034 Single requester master 1 repeatedly raising cyc -> granted each time after one IDLE cycle; s_ack_i with s_stb_o low -> m_ack_o stays 0.
